scope_trigger_capture: RTL and testbench
========================================

Name: scope_trigger_capture

Overview:
- Capture front end that sits directly upstream of the sample FIFO, in the write-clock domain.
- Accepts the ADC sample stream, arms on command and waits for a level-crossing trigger, either rising or falling edge.
- Once triggered, writes a programmed number of optionally decimated samples into the FIFO write port.
- Reports busy, triggered, done and overflow status to the control logic.

Parameters:
- DATA_SIZE, 12, sample width; matches the FIFO data width.
- CNT_SIZE, 8, capture-length counter width; the maximum capture is 2^CNT_SIZE samples.
- DECIM_SIZE, 4, decimation factor width.
- TMO_SIZE, 16, auto-trigger timeout counter width.

Ports:
- w_clk_i  in  1  capture clock; the same clock as the FIFO write side.
- w_rst_i  in  1  reset, synchronous, active-high.
- sample_i  in  DATA_SIZE  ADC sample, unsigned.
- sample_valid_i  in  1  sample_i is valid this cycle.
- arm_i  in  1  start-capture pulse.
- abort_i  in  1  abandon the current capture.
- trig_level_i  in  DATA_SIZE  trigger threshold.
- trig_falling_i  in  1  0 selects rising edge, 1 selects falling edge.
- auto_i  in  1  enable forced trigger on timeout.
- capture_len_i  in  CNT_SIZE  samples to write; 0 means 2^CNT_SIZE.
- decim_i  in  DECIM_SIZE  keep 1 of every decim_i+1 valid samples during capture.
- w_full_i  in  1  FIFO full flag.
- w_data_o  out  DATA_SIZE  FIFO write data.
- w_inc_o  out  1  FIFO write strobe.
- busy_o  out  1  state is not IDLE.
- triggered_o  out  1  trigger has occurred in the current capture.
- done_o  out  1  one-cycle completion pulse.
- overflow_o  out  1  sticky flag: at least one sample was dropped because the FIFO was full.

Behaviour:
- Reset: state IDLE. All outputs are 0. Internal registers are cleared: prev sample, prev_valid, counters, latched configuration.
- States and transitions:
  - IDLE -> WAIT_TRIG on arm_i. Entering WAIT_TRIG:
    - latch trig_level_i, trig_falling_i, auto_i, capture_len_i and decim_i;
    - clear overflow_o and triggered_o;
    - clear prev_valid and the timeout counter.
  - WAIT_TRIG, on each valid sample:
    - Rising trigger: prev_valid and prev < level and sample >= level.
    - Falling trigger: prev_valid and prev > level and sample <= level.
    - The first valid sample after arming never triggers; it only loads prev and sets prev_valid.
    - The timeout counter increments per valid sample. If the latched auto is 1 and the counter reaches 2^TMO_SIZE-1, the current sample forces the trigger.
    - On a trigger: set triggered_o, go to CAPTURE. The triggering sample is the first captured sample. The decimation counter loads decim.
  - CAPTURE:
    - The decimation counter decrements per valid sample. A sample is kept when the counter is 0, then the counter reloads decim. decim=0 keeps every sample.
    - Each kept sample decrements the remaining count.
    - After the last kept sample, go to DONE.
  - DONE: assert done_o for exactly one cycle, then go to IDLE. triggered_o and overflow_o hold until the next arm.
- Write path:
  - A kept sample with w_full_i=0 produces w_inc_o=1 and w_data_o=sample on the next cycle (1-cycle latency).
  - w_inc_o is high for one cycle per sample. w_data_o holds its last value otherwise.
  - A kept sample with w_full_i=1 is dropped: no w_inc_o, overflow_o is set. It still counts toward capture length, so capture timing is preserved.
- Boundary rules:
  - arm_i while busy_o=1 is ignored.
  - abort_i in any state returns to IDLE on the next edge. No done_o. A write registered in the abort cycle still issues. abort_i has priority over trigger and completion in the same cycle.
  - arm_i and abort_i together in IDLE: abort wins and the state stays IDLE.
  - Reset mid-capture behaves exactly as a fresh reset: any pending w_inc_o is suppressed.
  - sample_valid_i=0 cycles change no counters.
  - capture_len 0 writes 256 samples with the default CNT_SIZE.
  - A level equal to the sample counts as crossed in the edge direction only: rising needs prev < level, falling needs prev > level.

Test Plan:
- Rising trigger: level=0x800, len=4, decim=0; ramp 0x7F0, 0x7FE, 0x800, 0x810, 0x820, 0x830 -> trigger on 0x800; w_inc_o pulses carry 0x800, 0x810, 0x820, 0x830; done_o one cycle after the last write; busy_o low after.
- Falling trigger with decimation: level=0x400, falling, decim=2, len=3; descending ramp crossing at sample N -> samples N, N+3, N+6 written; exactly 3 w_inc_o pulses.
- Full backpressure: len=4; w_full_i high during the 2nd kept sample -> 3 writes, overflow_o=1, done_o still after the 4th kept sample; the next arm_i clears overflow_o.
- Auto timeout (TMO_SIZE=4 build): auto=1, constant input 0x100, level=0x800 -> forced trigger on the 15th valid sample, triggered_o=1, len samples written. Repeat with auto=0 -> no writes after 100 samples, busy_o=1.
- First-sample rule: arm, then first valid sample 0x900 with level 0x800, prev unknown -> no trigger; next sample 0x700 then 0x900 -> trigger on the second 0x900.
- Abort/reset: abort_i mid-capture after 2 writes -> IDLE next cycle, no done_o, no further w_inc_o. arm_i while busy is ignored. w_rst_i mid-capture -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/scope_trigger_capture.sv
// Oscilloscope capture front end: arms, waits for a level-crossing (or timeout)
// trigger, then writes a decimated, fixed-length burst into the FIFO write port.
module scope_trigger_capture #(
   parameter int unsigned DATA_SIZE  = 12,
   parameter int unsigned CNT_SIZE   = 8,
   parameter int unsigned DECIM_SIZE = 4,
   parameter int unsigned TMO_SIZE   = 16
) (
   input  logic                  w_clk_i,
   input  logic                  w_rst_i,
   input  logic [DATA_SIZE-1:0]  sample_i,
   input  logic                  sample_valid_i,
   input  logic                  arm_i,
   input  logic                  abort_i,
   input  logic [DATA_SIZE-1:0]  trig_level_i,
   input  logic                  trig_falling_i,
   input  logic                  auto_i,
   input  logic [CNT_SIZE-1:0]   capture_len_i,
   input  logic [DECIM_SIZE-1:0] decim_i,
   input  logic                  w_full_i,
   output logic [DATA_SIZE-1:0]  w_data_o,
   output logic                  w_inc_o,
   output logic                  busy_o,
   output logic                  triggered_o,
   output logic                  done_o,
   output logic                  overflow_o
);

   typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

   // Counter value seen on the sample just before the timeout counter saturates.
   localparam logic [TMO_SIZE-1:0] TMO_LAST = {{(TMO_SIZE-1){1'b1}}, 1'b0};
   localparam logic [CNT_SIZE-1:0] CNT_ONE  = {{(CNT_SIZE-1){1'b0}}, 1'b1};

   state_t                state;
   logic [DATA_SIZE-1:0]  prev;
   logic                  prev_valid;
   logic [DATA_SIZE-1:0]  level;
   logic                  falling;
   logic                  auto_en;
   logic [DECIM_SIZE-1:0] decim;
   logic [DECIM_SIZE-1:0] dec_cnt;
   logic [CNT_SIZE-1:0]   rem_cnt;
   logic [TMO_SIZE-1:0]   tmo_cnt;

   logic edge_hit;
   logic tmo_hit;
   logic trig;
   logic keep;
   logic last;

   always_comb begin
      edge_hit = 1'b0;
      if (prev_valid) begin
         if (falling) edge_hit = (prev > level) && (sample_i <= level);
         else         edge_hit = (prev < level) && (sample_i >= level);
      end
      tmo_hit = auto_en && (tmo_cnt == TMO_LAST);
      trig    = (state == WAIT_TRIG) && sample_valid_i && (edge_hit || tmo_hit);
      // The triggering sample is always kept; later ones only when decimation expires.
      keep    = trig || ((state == CAPTURE) && sample_valid_i && (dec_cnt == '0));
      last    = keep && (rem_cnt == CNT_ONE);
   end

   assign busy_o = (state != IDLE);

   always_ff @(posedge w_clk_i) begin
      if (w_rst_i) begin
         state       <= IDLE;
         prev        <= '0;
         prev_valid  <= 1'b0;
         level       <= '0;
         falling     <= 1'b0;
         auto_en     <= 1'b0;
         decim       <= '0;
         dec_cnt     <= '0;
         rem_cnt     <= '0;
         tmo_cnt     <= '0;
         w_data_o    <= '0;
         w_inc_o     <= 1'b0;
         triggered_o <= 1'b0;
         done_o      <= 1'b0;
         overflow_o  <= 1'b0;
      end else begin
         w_inc_o <= 1'b0;
         done_o  <= 1'b0;
         if (abort_i) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (arm_i) begin
                     state       <= WAIT_TRIG;
                     level       <= trig_level_i;
                     falling     <= trig_falling_i;
                     auto_en     <= auto_i;
                     rem_cnt     <= capture_len_i;
                     decim       <= decim_i;
                     overflow_o  <= 1'b0;
                     triggered_o <= 1'b0;
                     prev_valid  <= 1'b0;
                     tmo_cnt     <= '0;
                  end
               end
               WAIT_TRIG: begin
                  if (sample_valid_i) begin
                     prev       <= sample_i;
                     prev_valid <= 1'b1;
                     if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
                     if (trig) begin
                        triggered_o <= 1'b1;
                        dec_cnt     <= decim;
                        state       <= last ? DONE : CAPTURE;
                     end
                  end
               end
               CAPTURE: begin
                  if (sample_valid_i) begin
                     if (dec_cnt == '0) dec_cnt <= decim;
                     else               dec_cnt <= dec_cnt - 1'b1;
                     if (last) state <= DONE;
                  end
               end
               DONE: begin
                  done_o <= 1'b1;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase

            // Dropped samples still consume length so capture timing is preserved.
            if (keep) begin
               rem_cnt <= rem_cnt - 1'b1;
               if (w_full_i) begin
                  overflow_o <= 1'b1;
               end else begin
                  w_inc_o  <= 1'b1;
                  w_data_o <= sample_i;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Scoreboard bench for scope_trigger_capture: expected FIFO writes are queued by
// the stimulus and checked by a monitor whenever w_inc_o fires.
module tb_scope_trigger_capture;

   logic        w_clk_i = 1'b0;
   logic        w_rst_i;
   logic [11:0] sample_i;
   logic        sample_valid_i;
   logic        arm_i;
   logic        abort_i;
   logic [11:0] trig_level_i;
   logic        trig_falling_i;
   logic        auto_i;
   logic [7:0]  capture_len_i;
   logic [3:0]  decim_i;
   logic        w_full_i;
   logic [11:0] w_data_o;
   logic        w_inc_o;
   logic        busy_o;
   logic        triggered_o;
   logic        done_o;
   logic        overflow_o;

   scope_trigger_capture #(
      .DATA_SIZE  (12),
      .CNT_SIZE   (8),
      .DECIM_SIZE (4),
      .TMO_SIZE   (4)
   ) dut (
      .w_clk_i        (w_clk_i),
      .w_rst_i        (w_rst_i),
      .sample_i       (sample_i),
      .sample_valid_i (sample_valid_i),
      .arm_i          (arm_i),
      .abort_i        (abort_i),
      .trig_level_i   (trig_level_i),
      .trig_falling_i (trig_falling_i),
      .auto_i         (auto_i),
      .capture_len_i  (capture_len_i),
      .decim_i        (decim_i),
      .w_full_i       (w_full_i),
      .w_data_o       (w_data_o),
      .w_inc_o        (w_inc_o),
      .busy_o         (busy_o),
      .triggered_o    (triggered_o),
      .done_o         (done_o),
      .overflow_o     (overflow_o)
   );

   always #5 w_clk_i = ~w_clk_i;

   int n_checks = 0;
   int n_fail   = 0;
   int n_writes = 0;
   int n_done   = 0;
   int exp_done = 0;
   logic [11:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the head of the expected queue.
   always @(negedge w_clk_i) begin
      logic [11:0] e;
      if (w_inc_o === 1'b1) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got %0h expected no write", w_data_o);
         end else begin
            e = exp_q.pop_front();
            chk("w_data", {20'd0, w_data_o}, {20'd0, e});
         end
      end
      if (done_o === 1'b1) n_done++;
   end

   task automatic step(input logic v, input logic [11:0] s);
      sample_valid_i = v;
      sample_i       = s;
      @(posedge w_clk_i);
      #1;
      sample_valid_i = 1'b0;
   endtask

   task automatic arm(input logic [11:0] lvl, input logic fall, input logic au,
                      input logic [7:0] len, input logic [3:0] dec);
      trig_level_i   = lvl;
      trig_falling_i = fall;
      auto_i         = au;
      capture_len_i  = len;
      decim_i        = dec;
      arm_i          = 1'b1;
      @(posedge w_clk_i);
      #1;
      arm_i = 1'b0;
   endtask

   initial begin
      int w0;
      w_rst_i = 1'b1; sample_i = '0; sample_valid_i = 1'b0; arm_i = 1'b0; abort_i = 1'b0;
      trig_level_i = '0; trig_falling_i = 1'b0; auto_i = 1'b0; capture_len_i = '0;
      decim_i = '0; w_full_i = 1'b0;
      repeat (2) @(posedge w_clk_i);
      #1;
      chk("rst_w_inc", w_inc_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_outs", {w_data_o, triggered_o, done_o, overflow_o}, 0);
      w_rst_i = 1'b0;
      step(1'b0, 12'h0);

      // Rising trigger, no decimation.
      arm(12'h800, 1'b0, 1'b0, 8'd4, 4'd0);
      chk("t1_busy_armed", busy_o, 1);
      exp_q.push_back(12'h800); exp_q.push_back(12'h810);
      exp_q.push_back(12'h820); exp_q.push_back(12'h830);
      step(1'b1, 12'h7F0);
      step(1'b1, 12'h7FE);
      chk("t1_not_trig", triggered_o, 0);
      step(1'b1, 12'h800);
      chk("t1_trig", triggered_o, 1);
      step(1'b1, 12'h810);
      step(1'b1, 12'h820);
      step(1'b1, 12'h830);
      chk("t1_done_early", done_o, 0);
      step(1'b0, 12'h0);
      chk("t1_done", done_o, 1);
      chk("t1_busy_after", busy_o, 0);
      exp_done++;
      step(1'b0, 12'h0);
      chk("t1_done_one_cycle", done_o, 0);

      // Falling trigger with decimation 2, an invalid cycle in the middle.
      arm(12'h400, 1'b1, 1'b0, 8'd3, 4'd2);
      w0 = n_writes;
      exp_q.push_back(12'h400); exp_q.push_back(12'h3D0); exp_q.push_back(12'h3A0);
      step(1'b1, 12'h430); step(1'b1, 12'h420); step(1'b1, 12'h410);
      step(1'b1, 12'h400); step(1'b1, 12'h3F0); step(1'b0, 12'h123);
      step(1'b1, 12'h3E0); step(1'b1, 12'h3D0); step(1'b1, 12'h3C0);
      step(1'b1, 12'h3B0); step(1'b1, 12'h3A0);
      step(1'b0, 12'h0);
      chk("t2_done", done_o, 1);
      exp_done++;
      chk("t2_write_count", n_writes - w0, 3);

      // Backpressure on the second kept sample.
      arm(12'h800, 1'b0, 1'b0, 8'd4, 4'd0);
      exp_q.push_back(12'h900); exp_q.push_back(12'h920); exp_q.push_back(12'h930);
      step(1'b1, 12'h100);
      step(1'b1, 12'h900);
      w_full_i = 1'b1;
      step(1'b1, 12'h910);
      w_full_i = 1'b0;
      chk("t3_overflow", overflow_o, 1);
      step(1'b1, 12'h920);
      step(1'b1, 12'h930);
      step(1'b0, 12'h0);
      chk("t3_done", done_o, 1);
      chk("t3_overflow_hold", overflow_o, 1);
      exp_done++;

      // First valid sample after arming never triggers; len=1.
      arm(12'h800, 1'b0, 1'b0, 8'd1, 4'd0);
      chk("t5_overflow_cleared", overflow_o, 0);
      chk("t5_trig_cleared", triggered_o, 0);
      step(1'b1, 12'h900);
      chk("t5_first_no_trig", triggered_o, 0);
      step(1'b1, 12'h700);
      exp_q.push_back(12'h900);
      step(1'b1, 12'h900);
      chk("t5_trig", triggered_o, 1);
      step(1'b0, 12'h0);
      chk("t5_done", done_o, 1);
      exp_done++;

      // Auto timeout: forced trigger on the 15th valid sample.
      arm(12'h800, 1'b0, 1'b1, 8'd2, 4'd0);
      repeat (14) step(1'b1, 12'h100);
      chk("t4_no_trig_14", triggered_o, 0);
      exp_q.push_back(12'h100); exp_q.push_back(12'h100);
      step(1'b1, 12'h100);
      chk("t4_forced_trig", triggered_o, 1);
      step(1'b1, 12'h100);
      step(1'b0, 12'h0);
      chk("t4_done", done_o, 1);
      exp_done++;

      // No auto: stays waiting, then abort from WAIT_TRIG.
      arm(12'h800, 1'b0, 1'b0, 8'd2, 4'd0);
      repeat (100) step(1'b1, 12'h100);
      chk("t4b_no_trig", triggered_o, 0);
      chk("t4b_busy", busy_o, 1);
      abort_i = 1'b1;
      step(1'b0, 12'h0);
      abort_i = 1'b0;
      chk("t4b_abort_idle", busy_o, 0);

      // Abort mid-capture after 2 writes; arm while busy ignored.
      arm(12'h800, 1'b0, 1'b0, 8'd8, 4'd0);
      exp_q.push_back(12'h800); exp_q.push_back(12'h810);
      step(1'b1, 12'h700);
      step(1'b1, 12'h800);
      step(1'b1, 12'h810);
      arm(12'h100, 1'b1, 1'b0, 8'd1, 4'd0);
      chk("t6_arm_ignored_trig", triggered_o, 1);
      chk("t6_arm_ignored_busy", busy_o, 1);
      abort_i = 1'b1;
      step(1'b0, 12'h0);
      abort_i = 1'b0;
      chk("t6_abort_idle", busy_o, 0);
      chk("t6_abort_no_done", done_o, 0);
      repeat (5) step(1'b1, 12'h900);
      chk("t6_still_idle", busy_o, 0);

      // arm and abort together in IDLE.
      abort_i = 1'b1; arm_i = 1'b1;
      step(1'b0, 12'h0);
      abort_i = 1'b0; arm_i = 1'b0;
      chk("t6_arm_abort_idle", busy_o, 0);

      // Reset mid-capture suppresses the pending write.
      arm(12'h800, 1'b0, 1'b0, 8'd8, 4'd0);
      exp_q.push_back(12'h800);
      step(1'b1, 12'h700);
      step(1'b1, 12'h800);
      w_rst_i = 1'b1;
      step(1'b1, 12'h810);
      chk("t7_rst_w_inc", w_inc_o, 0);
      chk("t7_rst_busy", busy_o, 0);
      chk("t7_rst_outs", {w_data_o, triggered_o, done_o, overflow_o}, 0);
      w_rst_i = 1'b0;
      step(1'b0, 12'h0);

      // capture_len 0 writes 256 samples.
      arm(12'h800, 1'b0, 1'b0, 8'd0, 4'd0);
      w0 = n_writes;
      step(1'b1, 12'h000);
      for (int i = 0; i < 256; i++) begin
         exp_q.push_back(12'h800 + 12'(i));
         step(1'b1, 12'h800 + 12'(i));
      end
      chk("t8_done_early", done_o, 0);
      step(1'b0, 12'h0);
      chk("t8_done", done_o, 1);
      exp_done++;
      chk("t8_write_count", n_writes - w0, 256);

      step(1'b0, 12'h0);
      step(1'b0, 12'h0);
      chk("queue_empty", exp_q.size(), 0);
      chk("done_count", n_done, exp_done);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
